// File: rtl/pc_fetch.sv
// Instruction fetch stage: owns the PC, runs a req/ack handshake with instruction memory,
// and presents decoded instruction fields to IF/ID with a bubble flag when nothing is valid.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_4_IF,
  output logic [5:0]  op_IF,
  output logic [4:0]  Rs_IF,
  output logic [4:0]  Rt_IF,
  output logic [4:0]  Rd_IF,
  output logic [4:0]  Shamt_IF,
  output logic [5:0]  Func_IF,
  output logic        fetch_bubble
);

  typedef enum logic [1:0] {IDLE, FETCH, HAVE, DROP} state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] ir;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        have;
  logic [1:0]  unused_redirect_lsbs;

  assign target               = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = redirect_pc[1:0];
  assign pc_plus4             = pc + 32'd4;

  // A request that is in flight can never be withdrawn, so a redirect seen before the ack
  // parks in DROP and only re-requests once the stale word has been returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC_ALIGNED;
      req_addr <= RESET_PC_ALIGNED;
      ir       <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          req_addr <= pc;
          state    <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            pc <= target;
            if (imem_ack) req_addr <= target;
            else          state    <= DROP;
          end else if (imem_ack) begin
            ir    <= imem_rdata;
            state <= HAVE;
          end
        end
        HAVE: begin
          if (redirect) begin
            pc       <= target;
            req_addr <= target;
            state    <= FETCH;
          end else if (!stall) begin
            pc       <= pc_plus4;
            req_addr <= pc_plus4;
            state    <= FETCH;
          end
        end
        DROP: begin
          if (redirect) pc <= target;
          if (imem_ack) begin
            req_addr <= redirect ? target : pc;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state so no input reaches an output combinationally.
  assign have         = (state == HAVE);
  assign imem_req     = (state == FETCH) || (state == DROP);
  assign imem_addr    = req_addr;
  assign PC_4_IF      = pc_plus4;
  assign fetch_bubble = !have;
  assign op_IF        = have ? ir[31:26] : 6'd0;
  assign Rs_IF        = have ? ir[25:21] : 5'd0;
  assign Rt_IF        = have ? ir[20:16] : 5'd0;
  assign Rd_IF        = have ? ir[15:11] : 5'd0;
  assign Shamt_IF     = have ? ir[10:6]  : 5'd0;
  assign Func_IF      = have ? ir[5:0]   : 6'd0;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: reset, zero-wait streaming, delayed ack, stall,
// redirect in FETCH/HAVE/DROP, PC wrap and asynchronous reset mid-request.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC_4_IF;
  logic [5:0]  op_IF;
  logic [4:0]  Rs_IF;
  logic [4:0]  Rt_IF;
  logic [4:0]  Rd_IF;
  logic [4:0]  Shamt_IF;
  logic [5:0]  Func_IF;
  logic        fetch_bubble;
  logic [31:0] fields;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADD_WORD = 32'h012A_4020;
  localparam logic [31:0] LW_WORD  = 32'h8C48_0004;
  localparam logic [31:0] STALE    = 32'hDEAD_BEEF;

  pc_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC_4_IF(PC_4_IF),
    .op_IF(op_IF), .Rs_IF(Rs_IF), .Rt_IF(Rt_IF), .Rd_IF(Rd_IF),
    .Shamt_IF(Shamt_IF), .Func_IF(Func_IF), .fetch_bubble(fetch_bubble)
  );

  always #5 clk = ~clk;

  assign fields = {op_IF, Rs_IF, Rt_IF, Rd_IF, Shamt_IF, Func_IF};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    checks++;
    if ({imem_req, fetch_bubble} !== 2'b01) begin
      errors++; $display("FAIL reset_req_bubble got %b exp 01", {imem_req, fetch_bubble});
    end
    checks++;
    if (PC_4_IF !== 32'h4) begin
      errors++; $display("FAIL reset_pc4 got %h exp 00000004", PC_4_IF);
    end
    checks++;
    if (fields !== 32'h0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_fields_addr got %h/%h exp 0/0", fields, imem_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    imem_ack = 1'b1; imem_rdata = ADD_WORD;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4) || fetch_bubble !== 1'b1) begin
        errors++;
        $display("FAIL zw_fetch%0d got req=%b addr=%h bub=%b exp 1 %h 1", i, imem_req, imem_addr,
                 fetch_bubble, 32'(i * 4));
      end
      tick();
      checks++;
      if (imem_req !== 1'b0 || fetch_bubble !== 1'b0 || PC_4_IF !== 32'(i * 4 + 4) || fields !== ADD_WORD) begin
        errors++;
        $display("FAIL zw_have%0d got req=%b bub=%b pc4=%h f=%h exp 0 0 %h %h", i, imem_req,
                 fetch_bubble, PC_4_IF, fields, 32'(i * 4 + 4), ADD_WORD);
      end
      if (i == 0) begin
        checks++;
        if (op_IF !== 6'd0 || Rs_IF !== 5'd9 || Rt_IF !== 5'd10 || Rd_IF !== 5'd8 ||
            Shamt_IF !== 5'd0 || Func_IF !== 6'd32) begin
          errors++;
          $display("FAIL zw_fields got op=%0d rs=%0d rt=%0d rd=%0d sh=%0d fn=%0d exp 0 9 10 8 0 32",
                   op_IF, Rs_IF, Rt_IF, Rd_IF, Shamt_IF, Func_IF);
        end
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_ack_delay();
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10 || fetch_bubble !== 1'b1) begin
        errors++;
        $display("FAIL delay_c%0d got req=%b addr=%h bub=%b exp 1 00000010 1", c, imem_req,
                 imem_addr, fetch_bubble);
      end
    end
    imem_ack = 1'b1; imem_rdata = LW_WORD;
    tick();
    checks++;
    if (fields !== LW_WORD || op_IF !== 6'h23 || PC_4_IF !== 32'h14 || fetch_bubble !== 1'b0) begin
      errors++;
      $display("FAIL delay_have got f=%h op=%h pc4=%h bub=%b exp %h 23 00000014 0", fields, op_IF,
               PC_4_IF, fetch_bubble, LW_WORD);
    end
  endtask

  task automatic test_stall();
    imem_ack = 1'b0; stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (fields !== LW_WORD || PC_4_IF !== 32'h14 || fetch_bubble !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_c%0d got f=%h pc4=%h bub=%b req=%b exp %h 00000014 0 0", c, fields,
                 PC_4_IF, fetch_bubble, imem_req, LW_WORD);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      errors++; $display("FAIL stall_release got req=%b addr=%h exp 1 00000014", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_drop();
    redirect = 1'b1; redirect_pc = 32'h0040_0003;
    tick();
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14 || PC_4_IF !== 32'h0040_0004 || fetch_bubble !== 1'b1) begin
      errors++;
      $display("FAIL drop_enter got req=%b addr=%h pc4=%h bub=%b exp 1 00000014 00400004 1",
               imem_req, imem_addr, PC_4_IF, fetch_bubble);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14 || fetch_bubble !== 1'b1) begin
      errors++;
      $display("FAIL drop_hold got req=%b addr=%h bub=%b exp 1 00000014 1", imem_req, imem_addr, fetch_bubble);
    end
    imem_ack = 1'b1; imem_rdata = STALE;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000 || fetch_bubble !== 1'b1) begin
      errors++;
      $display("FAIL drop_refetch got req=%b addr=%h bub=%b exp 1 00400000 1", imem_req, imem_addr, fetch_bubble);
    end
    imem_rdata = ADD_WORD;
    tick();
    checks++;
    if (fields !== ADD_WORD || PC_4_IF !== 32'h0040_0004 || fetch_bubble !== 1'b0) begin
      errors++;
      $display("FAIL drop_have got f=%h pc4=%h bub=%b exp %h 00400004 0", fields, PC_4_IF,
               fetch_bubble, ADD_WORD);
    end
  endtask

  task automatic test_back_to_back();
    imem_ack = 1'b0; redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_1238;
    tick();
    stall = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h1238 || PC_4_IF !== 32'h123C || fetch_bubble !== 1'b1) begin
      errors++;
      $display("FAIL redir_stall got req=%b addr=%h pc4=%h bub=%b exp 1 00001238 0000123c 1",
               imem_req, imem_addr, PC_4_IF, fetch_bubble);
    end
    redirect_pc = 32'h0000_2001; imem_ack = 1'b1; imem_rdata = STALE;
    tick();
    redirect = 1'b0; imem_rdata = ADD_WORD;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h2000 || PC_4_IF !== 32'h2004 || fetch_bubble !== 1'b1) begin
      errors++;
      $display("FAIL redir_ack got req=%b addr=%h pc4=%h bub=%b exp 1 00002000 00002004 1",
               imem_req, imem_addr, PC_4_IF, fetch_bubble);
    end
    tick();
    checks++;
    if (fields !== ADD_WORD || PC_4_IF !== 32'h2004 || fetch_bubble !== 1'b0) begin
      errors++;
      $display("FAIL redir_have got f=%h pc4=%h bub=%b exp %h 00002004 0", fields, PC_4_IF,
               fetch_bubble, ADD_WORD);
    end
  endtask

  task automatic test_wrap();
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = LW_WORD;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || PC_4_IF !== 32'h0) begin
      errors++; $display("FAIL wrap_fetch got addr=%h pc4=%h exp fffffffc 00000000", imem_addr, PC_4_IF);
    end
    tick();
    imem_ack = 1'b0;
    checks++;
    if (PC_4_IF !== 32'h0 || fetch_bubble !== 1'b0 || fields !== LW_WORD) begin
      errors++;
      $display("FAIL wrap_have got pc4=%h bub=%b f=%h exp 00000000 0 %h", PC_4_IF, fetch_bubble, fields, LW_WORD);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || PC_4_IF !== 32'h4) begin
      errors++;
      $display("FAIL wrap_next got req=%b addr=%h pc4=%h exp 1 00000000 00000004", imem_req, imem_addr, PC_4_IF);
    end
  endtask

  task automatic test_async_reset();
    redirect = 1'b1; imem_ack = 1'b1; redirect_pc = 32'h0000_3000; imem_rdata = STALE;
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      errors++; $display("FAIL arst_pre got req=%b addr=%h exp 1 00003000", imem_req, imem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || PC_4_IF !== 32'h4 || fetch_bubble !== 1'b1) begin
      errors++;
      $display("FAIL arst_now got req=%b addr=%h pc4=%h bub=%b exp 0 00000000 00000004 1",
               imem_req, imem_addr, PC_4_IF, fetch_bubble);
    end
    imem_ack = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b0 || fields !== 32'h0) begin
      errors++; $display("FAIL arst_hold got req=%b f=%h exp 0 00000000", imem_req, fields);
    end
    rst_n = 1'b1; imem_rdata = ADD_WORD;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_bubble !== 1'b1) begin
      errors++;
      $display("FAIL arst_restart got req=%b addr=%h bub=%b exp 1 00000000 1", imem_req, imem_addr, fetch_bubble);
    end
    tick();
    checks++;
    if (fields !== ADD_WORD || PC_4_IF !== 32'h4 || fetch_bubble !== 1'b0) begin
      errors++;
      $display("FAIL arst_have got f=%h pc4=%h bub=%b exp %h 00000004 0", fields, PC_4_IF, fetch_bubble, ADD_WORD);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_ack_delay();
    test_stall();
    test_redirect_drop();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h00000000, word-aligned first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 stall  in  1  hold the presented instruction; same hazard-unit signal that drives the IF/ID register stall.
REQ-005 redirect  in  1  branch/jump taken; replaces the fetch stream.
REQ-006 redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-007 imem_req  out  1  instruction memory read request.
REQ-008 imem_addr  out  32  read address, word-aligned.
REQ-009 imem_ack  in  1  memory done; imem_rdata is valid in the ack cycle.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 PC_4_IF  out  32  address of the presented instruction plus 4.
REQ-012 op_IF[6], Rs_IF[5], Rt_IF[5], Rd_IF[5], Shamt_IF[5], Func_IF[6]  out  instruction fields [31:26],[25:21],[20:16],[15:11],[10:6],[5:0].
REQ-013 fetch_bubble  out  1  high when the fields carry no valid instruction; IF/ID flush is ORed with it.

Function
REQ-014 Registers: pc (32), req_addr (32), ir (32), state in {IDLE, FETCH, HAVE, DROP}.
REQ-015 Outputs are decoded from registered state only, with no combinational path from any input to any output.
REQ-016 imem_req is 1 in FETCH and DROP, 0 in IDLE and HAVE; imem_addr = req_addr at all times.
REQ-017 Handshake: imem_req and imem_addr stay stable from assertion until the cycle with imem_ack=1; imem_ack is ignored while imem_req=0.
REQ-018 In HAVE the fields equal slices of ir and fetch_bubble=0; in every other state the fields are all zero (NOP) and fetch_bubble=1.
REQ-019 PC_4_IF = pc + 4 modulo 2^32 in every state; 32'hFFFFFFFC yields 32'h00000000.
REQ-020 IDLE: unconditionally go to FETCH next cycle with req_addr <= pc.
REQ-021 FETCH, redirect=1, imem_ack=1: discard rdata; pc <= req_addr <= {redirect_pc[31:2],2'b00}; stay FETCH.
REQ-022 FETCH, redirect=1, imem_ack=0: pc <= aligned redirect_pc; req_addr unchanged; go DROP.
REQ-023 FETCH, redirect=0, imem_ack=1: ir <= imem_rdata; go HAVE.
REQ-024 FETCH, redirect=0, imem_ack=0: remain; stall is ignored in FETCH.
REQ-025 HAVE, redirect=1: pc <= req_addr <= aligned redirect_pc; go FETCH (the presented instruction is dropped).
REQ-026 HAVE, redirect=0, stall=0: pc <= req_addr <= pc+4; go FETCH.
REQ-027 HAVE, redirect=0, stall=1: hold all registers; outputs unchanged.
REQ-028 DROP: any redirect updates pc to the new aligned target and keeps DROP; on imem_ack, discard rdata, req_addr <= pc (including a same-cycle redirect target), go FETCH.
REQ-029 Redirect has priority over stall in every state.
REQ-030 Zero-wait memory: the cycle sequence is FETCH, HAVE, with 2 cycles per instruction and the instruction visible 1 cycle after ack.

Reset
REQ-031 While rst_n=0: state=IDLE, pc=req_addr=RESET_PC, ir=0; hence imem_req=0, fields=0, fetch_bubble=1, PC_4_IF=RESET_PC+4.
REQ-032 Reset asserted mid-request (FETCH/DROP) aborts immediately; the memory model sees imem_req fall asynchronously and any later ack is ignored.
REQ-033 The first posedge after rst_n rises leaves IDLE; the first request addresses RESET_PC.

Verification
REQ-034 Reset release, ack held 1, rdata=32'h012A4020, stall=0 -> addresses 0,4,8 on successive FETCH cycles; in HAVE op=0,Rs=9,Rt=10,Rd=8,Shamt=0,Func=32, PC_4_IF=4.
REQ-035 Ack delayed 3 cycles at addr 0x10 -> imem_req=1 and imem_addr=0x10 stable for all 4 cycles, fetch_bubble=1, then HAVE with ir=rdata.
REQ-036 HAVE with stall=1 for 5 cycles -> fields, PC_4_IF, fetch_bubble=0 unchanged and imem_req=0; on stall fall, next imem_addr=pc+4.
REQ-037 Redirect to 0x00400003 in FETCH before ack (ack 2 cycles later) -> DROP, stale data discarded, next request at 0x00400000, no HAVE in between.
REQ-038 Redirect and stall together in HAVE -> FETCH at target; redirect while ack=1 in FETCH -> stays FETCH, next addr=target.
REQ-039 pc=0xFFFFFFFC in HAVE, stall=0 -> PC_4_IF=0 and next request addr=0; rst_n pulsed low mid-FETCH -> imem_req=0 immediately and restart at RESET_PC.
